// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: word constants, fetch FSM states
// and the default address width.
package mips_pkg;

  localparam int          ADDR_W_DEFAULT    = 32;
  localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage : mips_pkg

// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage and its environment (control inputs,
// instruction-memory port and IF/ID outputs).
interface if_stage_if #(
  parameter int ADDR_W = mips_pkg::ADDR_W_DEFAULT
);

  logic [ADDR_W-1:0] start_pc;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       if_id_instr;
  logic [ADDR_W-1:0] if_id_pc_plus4;
  logic              if_id_valid;
  logic              halted;
  logic [31:0]       fetch_count;

  modport master (
    input  start_pc, stall, redirect_valid, redirect_pc, imem_rdata,
    output imem_addr, pc, if_id_instr, if_id_pc_plus4, if_id_valid,
           halted, fetch_count
  );

  modport slave (
    output start_pc, stall, redirect_valid, redirect_pc, imem_rdata,
    input  imem_addr, pc, if_id_instr, if_id_pc_plus4, if_id_valid,
           halted, fetch_count
  );

endinterface : if_stage_if

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid bit.
// Reset and flush insert a bubble; flush beats hold.
module if_id_reg
  import mips_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic              load,
  input  logic [31:0]       d_instr,
  input  logic [ADDR_W-1:0] d_pc_plus4,
  output logic [31:0]       q_instr,
  output logic [ADDR_W-1:0] q_pc_plus4,
  output logic              q_valid
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q_instr    <= NOP_WORD;
      q_pc_plus4 <= '0;
      q_valid    <= 1'b0;
    end else if (!hold && load) begin
      q_instr    <= d_instr;
      q_pc_plus4 <= d_pc_plus4;
      q_valid    <= 1'b1;
    end
  end

endmodule : if_id_reg

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, BOOT/RUN/HALT sequencing and a
// saturating fetch counter; the IF/ID register lives in if_id_reg.
module if_stage
  import mips_pkg::*;
#(
  parameter int          ADDR_W    = ADDR_W_DEFAULT,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  if_stage_if.master bus
);

  // Word alignment: the two low address bits are always cleared.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_plus4;
  logic [31:0]       count_q;
  logic              is_halt_word;
  logic              ifid_hold, ifid_flush, ifid_load, count_inc;

  assign is_halt_word = (bus.imem_rdata == HALT_WORD);
  assign pc_plus4     = pc_q + ADDR_W'(4);

  always_ff @(posedge clk) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN:  if (!bus.redirect_valid && !bus.stall && is_halt_word) state_d = HALT;
      HALT: if (bus.redirect_valid) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    ifid_load  = 1'b0;
    count_inc  = 1'b0;
    case (state_q)
      BOOT: begin
        // start_pc may only settle after reset, so it is sampled again here.
        pc_d       = bus.start_pc & ALIGN_MASK;
        ifid_flush = 1'b1;
      end
      RUN: begin
        if (bus.redirect_valid) begin
          pc_d       = bus.redirect_pc & ALIGN_MASK;
          ifid_flush = 1'b1;
        end else if (bus.stall) begin
          ifid_hold = 1'b1;
        end else if (is_halt_word) begin
          ifid_flush = 1'b1;
        end else begin
          pc_d      = pc_plus4;
          ifid_load = 1'b1;
          count_inc = 1'b1;
        end
      end
      HALT: begin
        ifid_flush = 1'b1;
        if (bus.redirect_valid) pc_d = bus.redirect_pc & ALIGN_MASK;
      end
      default: ifid_flush = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= bus.start_pc & ALIGN_MASK;
      count_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (count_inc && (count_q != '1)) count_q <= count_q + 32'd1;
    end
  end

  if_id_reg #(.ADDR_W(ADDR_W)) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .hold       (ifid_hold),
    .flush      (ifid_flush),
    .load       (ifid_load),
    .d_instr    (bus.imem_rdata),
    .d_pc_plus4 (pc_plus4),
    .q_instr    (bus.if_id_instr),
    .q_pc_plus4 (bus.if_id_pc_plus4),
    .q_valid    (bus.if_id_valid)
  );

  assign bus.pc          = pc_q;
  assign bus.imem_addr   = pc_q;
  assign bus.halted      = (state_q == HALT);
  assign bus.fetch_count = count_q;

endmodule : if_stage

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random
// stall/redirect/reset traffic, compared against a behavioural fetch model.
module tb_if_stage;

  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] mem [1024];

  if_stage_if #(.ADDR_W(32)) bus ();

  if_stage #(.ADDR_W(32), .HALT_WORD(HALT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Word-addressed instruction memory, 4 KiB window, asynchronous read.
  assign bus.imem_rdata = mem[bus.imem_addr[11:2]];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [31:0] m_pc     = 32'd0;
  logic [31:0] m_instr  = 32'd0;
  logic [31:0] m_pcp4   = 32'd0;
  logic [31:0] m_cnt    = 32'd0;
  bit          m_valid  = 1'b0;
  bit          m_boot   = 1'b1;
  bit          m_halted = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  task automatic bubble();
    m_instr = 32'd0;
    m_pcp4  = 32'd0;
    m_valid = 1'b0;
  endtask

  // Advance one clock edge, update the model from the inputs seen at that
  // edge, then compare every output.
  task automatic step();
    logic [31:0] w;
    w = mem[m_pc[11:2]];
    @(posedge clk);
    if (rst) begin
      m_pc = align(bus.start_pc); bubble(); m_cnt = 0; m_boot = 1; m_halted = 0;
    end else if (m_boot) begin
      m_pc = align(bus.start_pc); bubble(); m_boot = 0;
    end else if (m_halted) begin
      bubble();
      if (bus.redirect_valid) begin
        m_pc = align(bus.redirect_pc); m_halted = 0;
      end
    end else if (bus.redirect_valid) begin
      m_pc = align(bus.redirect_pc); bubble();
    end else if (bus.stall) begin
      // everything held
    end else if (w == HALT_W) begin
      bubble(); m_halted = 1;
    end else begin
      m_instr = w;
      m_pcp4  = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
    #1;
    check("pc",          bus.pc,             m_pc);
    check("imem_addr",   bus.imem_addr,      m_pc);
    check("if_id_instr", bus.if_id_instr,    m_instr);
    check("if_id_pcp4",  bus.if_id_pc_plus4, m_pcp4);
    check("if_id_valid", bus.if_id_valid,    m_valid);
    check("halted",      bus.halted,         m_halted);
    check("fetch_count", bus.fetch_count,    m_cnt);
  endtask

  task automatic drive(input bit s, input bit r, input logic [31:0] rp);
    bus.stall          = s;
    bus.redirect_valid = r;
    bus.redirect_pc    = rp;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      if (mem[i] == HALT_W) mem[i] = 32'h1234_5678;
    end
    rst = 1'b1;
    bus.start_pc = 32'd700;
    drive(0, 0, 32'd0);
    step(); step();
    check("rst_pc", bus.pc, 32'd700);

    // Straight-line fetch: BOOT, then three fetches.
    rst = 1'b0;
    step();
    check("boot_pc", bus.pc, 32'd700);
    step(); step();
    check("run_pcp4", bus.if_id_pc_plus4, 32'd708);
    step();
    check("count3", bus.fetch_count, 32'd3);

    // Two-cycle stall, then resume.
    drive(1, 0, 32'd0); step(); step();
    check("stall_pc", bus.pc, 32'd712);
    drive(0, 0, 32'd0); step();
    check("resume_pcp4", bus.if_id_pc_plus4, 32'd716);

    // Redirect beats stall; low target bits dropped.
    drive(1, 1, 32'h3FF); step();
    check("redir_pc", bus.pc, 32'h3FC);
    drive(0, 0, 32'd0); step();

    // Halt word at 720: frozen for 10 cycles, then redirect to 800.
    mem[720 >> 2] = HALT_W;
    drive(0, 1, 32'd712); step();
    drive(0, 0, 32'd0); step(); step(); step();
    check("halt_flag", bus.halted, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive($urandom_range(1), 0, 32'd0); step();
      check("halt_pc", bus.pc, 32'd720);
    end
    drive(0, 1, 32'd800); step();
    check("unhalt_pc", bus.pc, 32'd800);
    mem[720 >> 2] = 32'h0000_0020;
    drive(0, 0, 32'd0); step();

    // Wrap of pc+4 at the top of the address space.
    drive(0, 1, 32'hFFFF_FFFC); step();
    drive(0, 0, 32'd0); step();
    check("wrap_pc", bus.pc, 32'd0);
    check("wrap_pcp4", bus.if_id_pc_plus4, 32'd0);
    step();

    // Reset mid-run with a new, unaligned boot address.
    bus.start_pc = 32'h0000_0123;
    rst = 1'b1; step();
    check("rerst_pc", bus.pc, 32'h120);
    rst = 1'b0; step(); step();

    // Random traffic with scattered halt words.
    for (int i = 0; i < 24; i++) mem[$urandom_range(1023)] = HALT_W;
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(99) < 2);
      if ($urandom_range(9) == 0) bus.start_pc = $urandom_range(4095);
      drive($urandom_range(99) < 25, $urandom_range(99) < 10, $urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_if_stage
